// File: rtl/ff_pkg.sv
// Shared types and constants for the flip-flop RAM access controller.
// The RWS encodings must match the single-port RAM's read/write select.
package ff_pkg;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_t;

    localparam logic RWS_WRITE = 1'b1;
    localparam logic RWS_READ  = 1'b0;

    // One extra bit so the occupancy can represent a completely full RAM.
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/ff_ptr_cnt.sv
// Wrapping RAM pointer with synchronous clear and increment enable.
// Used for both the write and the read side of the controller.
module ff_ptr_cnt
    import ff_pkg::*;
#(
    parameter int ADDR_WIDTH = 3
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] ptr
);

    // Depth is a power of two, so plain overflow gives the DEPTH-1 -> 0 wrap.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/ff_ram_ctrl.sv
// Push/pop access scheduler for a single-port flip-flop RAM: one access per cycle,
// round-robin on conflict. Optional almost flags under FF_RAM_CTRL_ALMOST_EN.
module ff_ram_ctrl
    import ff_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 1 << ADDR_WIDTH,
`ifdef FF_RAM_CTRL_ALMOST_EN
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1,
`endif
    parameter int DATA_WIDTH = 8
)(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push_req,
    input  logic [DATA_WIDTH-1:0]            push_data,
    output logic                             push_ack,
    input  logic                             pop_req,
    output logic                             pop_ack,
    output logic [DATA_WIDTH-1:0]            pop_data,
    output logic                             pop_valid,
    input  logic                             flush,
    output logic                             full,
    output logic                             empty,
    output logic [count_width(ADDR_WIDTH)-1:0] count,
`ifdef FF_RAM_CTRL_ALMOST_EN
    output logic                             almost_full,
    output logic                             almost_empty,
`endif
    output logic                             ram_cs,
    output logic                             ram_rws,
    output logic [ADDR_WIDTH-1:0]            ram_wptr,
    output logic [ADDR_WIDTH-1:0]            ram_rptr,
    output logic [DATA_WIDTH-1:0]            ram_wdata,
    input  logic [DATA_WIDTH-1:0]            ram_rdata
);

    localparam int             CW      = count_width(ADDR_WIDTH);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    grant_t                  last_grant;
    grant_t                  last_grant_next;
    logic                    push_ok;
    logic                    pop_ok;
    logic                    grant_wr;
    logic                    grant_rd;
    logic [CW-1:0]           count_q;
    logic [CW-1:0]           count_next;
    logic [ADDR_WIDTH-1:0]   wptr;
    logic [ADDR_WIDTH-1:0]   rptr;

    // Reset and flush both block grants so nothing is recorded in those cycles.
    assign push_ok = push_req & ~full  & ~rst & ~flush;
    assign pop_ok  = pop_req  & ~empty & ~rst & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GRANT_RD;
        end else begin
            last_grant <= last_grant_next;
        end
    end

    always_comb begin
        grant_wr        = 1'b0;
        grant_rd        = 1'b0;
        last_grant_next = last_grant;
        if (push_ok && pop_ok) begin
            if (last_grant == GRANT_RD) begin
                grant_wr = 1'b1;
            end else begin
                grant_rd = 1'b1;
            end
        end else begin
            grant_wr = push_ok;
            grant_rd = pop_ok;
        end
        if (grant_wr) begin
            last_grant_next = GRANT_WR;
        end else if (grant_rd) begin
            last_grant_next = GRANT_RD;
        end
    end

    always_comb begin
        push_ack  = grant_wr;
        pop_ack   = grant_rd;
        ram_cs    = grant_wr | grant_rd;
        ram_rws   = grant_wr ? RWS_WRITE : RWS_READ;
        ram_wptr  = wptr;
        ram_rptr  = rptr;
        ram_wdata = push_data;
    end

    ff_ptr_cnt #(.ADDR_WIDTH(ADDR_WIDTH)) u_wptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (grant_wr),
        .ptr (wptr)
    );

    ff_ptr_cnt #(.ADDR_WIDTH(ADDR_WIDTH)) u_rptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (grant_rd),
        .ptr (rptr)
    );

    // Grants are mutually exclusive, so count moves by at most one per cycle.
    always_comb begin
        count_next = count_q;
        if (flush) begin
            count_next = '0;
        end else if (grant_wr) begin
            count_next = count_q + 1'b1;
        end else if (grant_rd) begin
            count_next = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_next;
        end
    end

    assign count = count_q;
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // pop_data is held through flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pop_valid <= 1'b0;
            pop_data  <= '0;
        end else begin
            pop_valid <= grant_rd;
            if (grant_rd) begin
                pop_data <= ram_rdata;
            end
        end
    end

`ifdef FF_RAM_CTRL_ALMOST_EN
    localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C = CW'(AE_LEVEL);

    always_ff @(posedge clk) begin
        if (rst) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (count_next >= AF_C);
            almost_empty <= (count_next <= AE_C);
        end
    end
`endif

endmodule

// File: tb/tb_ff_ram_ctrl.sv
// Self-checking bench for ff_ram_ctrl: reference model plus a data scoreboard
// and a behavioural single-port RAM with asynchronous read.
module tb_ff_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       push_req;
    logic [7:0] push_data;
    logic       push_ack;
    logic       pop_req;
    logic       pop_ack;
    logic [7:0] pop_data;
    logic       pop_valid;
    logic       flush;
    logic       full;
    logic       empty;
    logic [3:0] count;
`ifdef FF_RAM_CTRL_ALMOST_EN
    logic       almost_full;
    logic       almost_empty;
`endif
    logic       ram_cs;
    logic       ram_rws;
    logic [2:0] ram_wptr;
    logic [2:0] ram_rptr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    logic [7:0] mem [8];

    int checks = 0;
    int errors = 0;

    logic [3:0] m_count;
    logic [2:0] m_wptr;
    logic [2:0] m_rptr;
    logic       m_lg_rd;
    logic       m_valid;
    logic [7:0] m_pop_data;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_cs && ram_rws) mem[ram_wptr] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_rptr];

    ff_ram_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .push_req     (push_req),
        .push_data    (push_data),
        .push_ack     (push_ack),
        .pop_req      (pop_req),
        .pop_ack      (pop_ack),
        .pop_data     (pop_data),
        .pop_valid    (pop_valid),
        .flush        (flush),
        .full         (full),
        .empty        (empty),
        .count        (count),
`ifdef FF_RAM_CTRL_ALMOST_EN
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`endif
        .ram_cs       (ram_cs),
        .ram_rws      (ram_rws),
        .ram_wptr     (ram_wptr),
        .ram_rptr     (ram_rptr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle (called 1ns after a rising edge), checks the
    // combinational grant outputs mid-cycle, then the registered state after the edge.
    task automatic applyStimulus(input logic r, input logic p, input logic [7:0] d,
                                 input logic q, input logic f);
        logic pok, qok, gw, gr;
        rst = r; push_req = p; push_data = d; pop_req = q; flush = f;
        #3;
        pok = p & (m_count != 4'd8) & ~r & ~f;
        qok = q & (m_count != 4'd0) & ~r & ~f;
        gw  = pok & (~qok | m_lg_rd);
        gr  = qok & (~pok | ~m_lg_rd);
        checkOutput("push_ack", push_ack, gw);
        checkOutput("pop_ack",  pop_ack,  gr);
        checkOutput("ram_cs",   ram_cs,   gw | gr);
        checkOutput("ram_rws",  ram_rws,  gw);
        checkOutput("ram_wptr", ram_wptr, m_wptr);
        checkOutput("ram_rptr", ram_rptr, m_rptr);
        if (gw) sb.push_back(d);
        @(posedge clk);
        #1;
        if (r) begin
            m_count = 0; m_wptr = 0; m_rptr = 0; m_lg_rd = 1'b1;
            m_valid = 1'b0; m_pop_data = 8'h00; sb.delete();
        end else if (f) begin
            m_count = 0; m_wptr = 0; m_rptr = 0; m_valid = 1'b0; sb.delete();
        end else begin
            if (gw) begin
                m_wptr = m_wptr + 3'd1; m_count = m_count + 4'd1; m_lg_rd = 1'b0;
            end
            if (gr) begin
                m_pop_data = sb.pop_front();
                m_rptr = m_rptr + 3'd1; m_count = m_count - 4'd1; m_lg_rd = 1'b1;
            end
            m_valid = gr;
        end
        checkOutput("count",     count,     m_count);
        checkOutput("empty",     empty,     m_count == 4'd0);
        checkOutput("full",      full,      m_count == 4'd8);
        checkOutput("pop_valid", pop_valid, m_valid);
        checkOutput("pop_data",  pop_data,  m_pop_data);
`ifdef FF_RAM_CTRL_ALMOST_EN
        checkOutput("almost_full",  almost_full,  m_count >= 4'd7);
        checkOutput("almost_empty", almost_empty, m_count <= 4'd1);
`endif
    endtask

    initial begin
        rst = 1'b1; push_req = 1'b0; push_data = 8'h00; pop_req = 1'b0; flush = 1'b0;
        m_count = 0; m_wptr = 0; m_rptr = 0; m_lg_rd = 1'b1; m_valid = 1'b0; m_pop_data = 8'h00;
        @(posedge clk);
        #1;

        $display("[TB] reset with requests asserted");
        applyStimulus(1'b1, 1'b1, 8'hAA, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'hAA, 1'b1, 1'b0);

        $display("[TB] three pushes, then four pops");
        applyStimulus(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
        checkOutput("count_after_3_pushes", count, 32'd3);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("last_pop_data", pop_data, 32'h33);
        checkOutput("empty_after_drain", empty, 32'd1);

        $display("[TB] fill to full, blocked push, pop frees a slot");
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
        checkOutput("full_at_depth", full, 32'd1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h99, 1'b1, 1'b0);
        checkOutput("pop_data_first_of_full", pop_data, 32'h40);
        applyStimulus(1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        $display("[TB] contention at count 4");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'hC0 + 8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        $display("[TB] pointer wrap with alternating push/pop");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkOutput("wrap_last_data", pop_data, 32'h5B);

        $display("[TB] flush at count 5 with push pending");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hEE, 1'b0, 1'b1);
        checkOutput("count_after_flush", count, 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        $display("[TB] reset around a pop grant");
        applyStimulus(1'b0, 1'b1, 8'hA1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hA2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("pop_valid_after_reset", pop_valid, 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
